// File: rtl/lif_pkg.sv
//==============================================================================
// Module      : lif_pkg
// Description : Shared types and constants for the LIF neuron array.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package lif_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } lif_state_e;

    localparam logic RESET_SUB  = 1'b0;
    localparam logic RESET_ZERO = 1'b1;

    // Saturation limits of a signed value of the given width
    function automatic longint max_pos(input int width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    function automatic longint min_neg(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

`default_nettype wire

// File: rtl/lif_core.sv
//==============================================================================
// Module      : lif_core
// Description : Combinational single-neuron leaky integrate-and-fire update.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module lif_core
    import lif_pkg::*;
#(
    parameter int MEM_WIDTH   = 24,
    parameter int IN_WIDTH    = 18,
    parameter int COUNT_WIDTH = 4,
    parameter int REF_WIDTH   = 3,
    parameter int TAU_WIDTH   = 3
) (
    input  logic signed [MEM_WIDTH-1:0] v_in,
    input  logic [COUNT_WIDTH-1:0]      cnt_in,
    input  logic [REF_WIDTH-1:0]        ref_in,
    input  logic signed [IN_WIDTH-1:0]  cur_in,
    input  logic signed [MEM_WIDTH-1:0] cfg_v_th,
    input  logic [TAU_WIDTH-1:0]        cfg_tau_shift,
    input  logic                        cfg_reset_mode,
    input  logic [REF_WIDTH-1:0]        cfg_ref_period,
    output logic signed [MEM_WIDTH-1:0] v_next,
    output logic [COUNT_WIDTH-1:0]      cnt_next,
    output logic [REF_WIDTH-1:0]        ref_next,
    output logic                        fired
);

    localparam logic signed [MEM_WIDTH:0] c_sat_hi = (MEM_WIDTH+1)'(max_pos(MEM_WIDTH));
    localparam logic signed [MEM_WIDTH:0] c_sat_lo = (MEM_WIDTH+1)'(min_neg(MEM_WIDTH));

    logic signed [MEM_WIDTH-1:0] w_shifted;
    logic signed [MEM_WIDTH-1:0] w_decay;
    logic signed [MEM_WIDTH:0]   w_sum;
    logic signed [MEM_WIDTH-1:0] w_clamped;
    logic signed [MEM_WIDTH-1:0] w_v_sat;
    logic                        w_refractory;

    // Leak: arithmetic shift keeps negative membranes drifting toward zero
    assign w_shifted    = v_in >>> cfg_tau_shift;
    assign w_decay      = v_in - w_shifted;
    assign w_refractory = (ref_in != '0);

    assign w_sum = {w_decay[MEM_WIDTH-1], w_decay}
                 + {{(MEM_WIDTH+1-IN_WIDTH){cur_in[IN_WIDTH-1]}}, cur_in};

    always_comb begin
        w_clamped = w_sum[MEM_WIDTH-1:0];
        if (w_sum > c_sat_hi) begin
            w_clamped = c_sat_hi[MEM_WIDTH-1:0];
        end else if (w_sum < c_sat_lo) begin
            w_clamped = c_sat_lo[MEM_WIDTH-1:0];
        end
    end

    assign w_v_sat = w_refractory ? w_decay : w_clamped;
    assign fired   = !w_refractory && (w_v_sat >= cfg_v_th);

    always_comb begin
        v_next   = w_v_sat;
        cnt_next = cnt_in;
        ref_next = '0;
        if (w_refractory) begin
            ref_next = ref_in - REF_WIDTH'(1);
        end else if (fired) begin
            v_next   = (cfg_reset_mode == RESET_ZERO) ? '0 : (w_v_sat - cfg_v_th);
            ref_next = cfg_ref_period;
            if (cnt_in != '1) begin
                cnt_next = cnt_in + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/lif_array.sv
//==============================================================================
// Module      : lif_array
// Description : Time-multiplexed LIF neuron array with clear sweep and
//               registered, backpressured result stream.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module lif_array
    import lif_pkg::*;
#(
    parameter int N_NEURON    = 16,
    parameter int IDX_WIDTH   = 4,
    parameter int MEM_WIDTH   = 24,
    parameter int IN_WIDTH    = 18,
    parameter int COUNT_WIDTH = 4,
    parameter int REF_WIDTH   = 3,
    parameter int TAU_WIDTH   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [MEM_WIDTH-1:0]   cfg_v_th,
    input  logic [TAU_WIDTH-1:0]   cfg_tau_shift,
    input  logic                   cfg_reset_mode,
    input  logic [REF_WIDTH-1:0]   cfg_ref_period,
    input  logic                   clear_req,
    output logic                   busy,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IDX_WIDTH-1:0]   in_idx,
    input  logic [IN_WIDTH-1:0]    in_cur,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [IDX_WIDTH-1:0]   out_idx,
    output logic                   out_spike,
    output logic [MEM_WIDTH-1:0]   out_v,
    output logic [COUNT_WIDTH-1:0] out_cnt
);

    logic signed [MEM_WIDTH-1:0] mem_q [N_NEURON];
    logic signed [MEM_WIDTH-1:0] mem_d [N_NEURON];
    logic [COUNT_WIDTH-1:0]      cnt_q [N_NEURON];
    logic [COUNT_WIDTH-1:0]      cnt_d [N_NEURON];
    logic [REF_WIDTH-1:0]        ref_q [N_NEURON];
    logic [REF_WIDTH-1:0]        ref_d [N_NEURON];

    lif_state_e                  state_q, state_d;
    logic [IDX_WIDTH-1:0]        ptr_q, ptr_d;

    logic                        out_valid_q, out_valid_d;
    logic [IDX_WIDTH-1:0]        out_idx_q, out_idx_d;
    logic                        out_spike_q, out_spike_d;
    logic signed [MEM_WIDTH-1:0] out_v_q, out_v_d;
    logic [COUNT_WIDTH-1:0]      out_cnt_q, out_cnt_d;

    logic                        w_accept;
    logic                        w_idx_ok;
    logic signed [MEM_WIDTH-1:0] w_rd_v;
    logic [COUNT_WIDTH-1:0]      w_rd_cnt;
    logic [REF_WIDTH-1:0]        w_rd_ref;
    logic signed [MEM_WIDTH-1:0] w_v_next;
    logic [COUNT_WIDTH-1:0]      w_cnt_next;
    logic [REF_WIDTH-1:0]        w_ref_next;
    logic                        w_fired;

    // clear_req wins over a beat offered in the same cycle
    assign in_ready = (state_q == RUN) && !clear_req && (!out_valid_q || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_idx_ok = (32'(in_idx) < N_NEURON);
    assign busy     = (state_q == CLEAR);

    always_comb begin
        w_rd_v   = '0;
        w_rd_cnt = '0;
        w_rd_ref = '0;
        for (int i = 0; i < N_NEURON; i++) begin
            if (32'(in_idx) == i) begin
                w_rd_v   = mem_q[i];
                w_rd_cnt = cnt_q[i];
                w_rd_ref = ref_q[i];
            end
        end
    end

    lif_core #(
        .MEM_WIDTH   (MEM_WIDTH),
        .IN_WIDTH    (IN_WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH),
        .REF_WIDTH   (REF_WIDTH),
        .TAU_WIDTH   (TAU_WIDTH)
    ) u_core (
        .v_in           (w_rd_v),
        .cnt_in         (w_rd_cnt),
        .ref_in         (w_rd_ref),
        .cur_in         (in_cur),
        .cfg_v_th       (cfg_v_th),
        .cfg_tau_shift  (cfg_tau_shift),
        .cfg_reset_mode (cfg_reset_mode),
        .cfg_ref_period (cfg_ref_period),
        .v_next         (w_v_next),
        .cnt_next       (w_cnt_next),
        .ref_next       (w_ref_next),
        .fired          (w_fired)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            RUN: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                if (ptr_q == IDX_WIDTH'(N_NEURON - 1)) begin
                    state_d = RUN;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + IDX_WIDTH'(1);
                end
            end
            default: begin
                state_d = RUN;
                ptr_d   = '0;
            end
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        ref_d = ref_q;
        for (int i = 0; i < N_NEURON; i++) begin
            if (state_q == CLEAR) begin
                if (32'(ptr_q) == i) begin
                    mem_d[i] = '0;
                    cnt_d[i] = '0;
                    ref_d[i] = '0;
                end
            end else if (w_accept && w_idx_ok && (32'(in_idx) == i)) begin
                mem_d[i] = w_v_next;
                cnt_d[i] = w_cnt_next;
                ref_d[i] = w_ref_next;
            end
        end
    end

    // Result register holds while stalled; reloads as the old beat drains
    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
        out_idx_d   = out_idx_q;
        out_spike_d = out_spike_q;
        out_v_d     = out_v_q;
        out_cnt_d   = out_cnt_q;
        if (w_accept) begin
            out_valid_d = 1'b1;
            out_idx_d   = in_idx;
            out_spike_d = w_idx_ok && w_fired;
            out_v_d     = w_idx_ok ? w_v_next : '0;
            out_cnt_d   = w_idx_ok ? w_cnt_next : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_NEURON; i++) begin
                mem_q[i] <= '0;
                cnt_q[i] <= '0;
                ref_q[i] <= '0;
            end
            state_q     <= RUN;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_spike_q <= 1'b0;
            out_v_q     <= '0;
            out_cnt_q   <= '0;
        end else begin
            mem_q       <= mem_d;
            cnt_q       <= cnt_d;
            ref_q       <= ref_d;
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_spike_q <= out_spike_d;
            out_v_q     <= out_v_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_spike = out_spike_q;
    assign out_v     = out_v_q;
    assign out_cnt   = out_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_lif_array.sv
//==============================================================================
// Module      : tb_lif_array
// Description : Self-checking bench for lif_array against a behavioural model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_lif_array;

    localparam int N   = 16;
    localparam int IW  = 4;
    localparam int MW  = 24;
    localparam int INW = 18;
    localparam int CW  = 4;
    localparam int RW  = 3;
    localparam int TW  = 3;
    localparam longint MAXP = (longint'(1) <<< (MW - 1)) - 1;
    localparam longint MINN = -(longint'(1) <<< (MW - 1));
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [MW-1:0] cfg_v_th = '0;
    logic [TW-1:0] cfg_tau_shift = '0;
    logic          cfg_reset_mode = 1'b0;
    logic [RW-1:0] cfg_ref_period = '0;
    logic          clear_req = 1'b0;
    logic          busy;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_idx = '0;
    logic [INW-1:0] in_cur = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [IW-1:0] out_idx;
    logic          out_spike;
    logic [MW-1:0] out_v;
    logic [CW-1:0] out_cnt;

    always #5 clk = ~clk;

    lif_array #(
        .N_NEURON(N), .IDX_WIDTH(IW), .MEM_WIDTH(MW), .IN_WIDTH(INW),
        .COUNT_WIDTH(CW), .REF_WIDTH(RW), .TAU_WIDTH(TW)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_v_th(cfg_v_th), .cfg_tau_shift(cfg_tau_shift),
        .cfg_reset_mode(cfg_reset_mode), .cfg_ref_period(cfg_ref_period),
        .clear_req(clear_req), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx), .in_cur(in_cur),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_spike(out_spike), .out_v(out_v), .out_cnt(out_cnt)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int     idx;
        bit     sp;
        longint v;
        int     c;
    } beat_t;

    longint m_v [N];
    int     m_c [N];
    int     m_r [N];
    beat_t  sb [$];

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_v[i] = 0;
            m_c[i] = 0;
            m_r[i] = 0;
        end
    endfunction

    // Neuron behaviour from the rules, using plain integer arithmetic
    function automatic void model_step(input int idx, input longint cur, output beat_t b);
        longint v, d, s, th, q;
        b.idx = idx; b.sp = 1'b0; b.v = 0; b.c = 0;
        if (idx >= N) return;
        th = longint'($signed(cfg_v_th));
        v  = m_v[idx];
        q  = v / (longint'(1) << cfg_tau_shift);
        if (v < 0 && q * (longint'(1) << cfg_tau_shift) != v) q = q - 1;
        d  = v - q;
        if (m_r[idx] > 0) begin
            s = d;
            m_r[idx] = m_r[idx] - 1;
        end else begin
            s = d + cur;
            if (s > MAXP) s = MAXP;
            if (s < MINN) s = MINN;
            if (s >= th) begin
                b.sp = 1'b1;
                s = cfg_reset_mode ? 0 : s - th;
                m_r[idx] = int'(cfg_ref_period);
                if (m_c[idx] < CNT_MAX) m_c[idx] = m_c[idx] + 1;
            end
        end
        m_v[idx] = s;
        b.v = s;
        b.c = m_c[idx];
    endfunction

    function automatic longint dut_v();
        return longint'($signed(out_v));
    endfunction

    task automatic send(input int idx, input longint cur, output beat_t b);
        in_valid  = 1'b1;
        in_idx    = IW'(idx);
        in_cur    = INW'(cur);
        out_ready = 1'b1;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL send_ready idx=%0d: in_ready=%b want 1", idx, in_ready);
        else n_pass++;
        model_step(idx, cur, b);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic set_cfg(input longint th, input int tau, input bit mode, input int refp);
        cfg_v_th       = MW'(th);
        cfg_tau_shift  = TW'(tau);
        cfg_reset_mode = mode;
        cfg_ref_period = RW'(refp);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        n_total++;
        if (out_valid !== 1'b0 || out_idx !== '0 || out_spike !== 1'b0 || out_v !== '0
            || out_cnt !== '0 || busy !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset: valid=%b idx=%0d sp=%b v=%0d cnt=%0d busy=%b rdy=%b want 0/0/0/0/0/0/1",
                     out_valid, out_idx, out_spike, out_v, out_cnt, busy, in_ready);
        else n_pass++;
    endtask

    task automatic test_subtract_fire();
        beat_t b;
        set_cfg(1000, 2, 1'b0, 0);
        for (int k = 0; k < 3; k++) begin
            send(3, 600, b);
            n_total++;
            if (out_valid !== 1'b1 || int'(out_idx) != b.idx || out_spike !== b.sp
                || dut_v() != b.v || int'(out_cnt) != b.c)
                $display("FAIL subtract[%0d]: got v=%b i=%0d s=%b v=%0d c=%0d want i=%0d s=%b v=%0d c=%0d",
                         k, out_valid, out_idx, out_spike, dut_v(), out_cnt, b.idx, b.sp, b.v, b.c);
            else n_pass++;
        end
    endtask

    task automatic test_zero_refractory();
        beat_t b;
        set_cfg(1000, 2, 1'b1, 2);
        for (int k = 0; k < 4; k++) begin
            send(5, 1200, b);
            n_total++;
            if (out_valid !== 1'b1 || int'(out_idx) != b.idx || out_spike !== b.sp
                || dut_v() != b.v || int'(out_cnt) != b.c)
                $display("FAIL zero_ref[%0d]: got i=%0d s=%b v=%0d c=%0d want i=%0d s=%b v=%0d c=%0d",
                         k, out_idx, out_spike, dut_v(), out_cnt, b.idx, b.sp, b.v, b.c);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        beat_t b;
        int spikes = 0;
        int bad = 0;
        set_cfg(MAXP, 7, 1'b0, 0);
        for (int k = 0; k < 1700; k++) begin
            send(0, 131071, b);
            if (b.sp) spikes++;
            n_total++;
            if (out_spike !== b.sp || dut_v() != b.v || int'(out_cnt) != b.c) begin
                bad++;
                if (bad < 6)
                    $display("FAIL saturate[%0d]: got s=%b v=%0d c=%0d want s=%b v=%0d c=%0d",
                             k, out_spike, dut_v(), out_cnt, b.sp, b.v, b.c);
            end else n_pass++;
        end
        n_total++;
        if (spikes < 17 || int'(out_cnt) != CNT_MAX)
            $display("FAIL saturate_cnt: spikes=%0d cnt=%0d want >=17 and %0d", spikes, out_cnt, CNT_MAX);
        else n_pass++;
    endtask

    // Cycle-level stream with a scoreboard; hold cycles keep out_ready low
    task automatic run_stream(input int ncyc, input int hold, input bit rand_mode, input string tag);
        beat_t b, e;
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < ncyc; c++) begin
            in_valid = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_idx   = IW'($urandom_range(0, N - 1));
            in_cur   = INW'($urandom);
            if (rand_mode && $urandom_range(0, 3) == 0)
                set_cfg($urandom_range(1, 200000), $urandom_range(0, 7),
                        1'($urandom_range(0, 1)), $urandom_range(0, 3));
            out_ready = (c < hold) ? 1'b0 : (rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1);
            #1;
            if (c >= 1 && c < hold) begin
                n_total++;
                if (in_ready !== 1'b0) $display("FAIL %s_stall_ready[%0d]: in_ready=%b want 0", tag, c, in_ready);
                else n_pass++;
            end
            n_total++;
            if (out_valid !== (sb.size() != 0)) begin
                $display("FAIL %s_valid[%0d]: out_valid=%b want %b", tag, c, out_valid, sb.size() != 0);
            end else if (sb.size() != 0) begin
                e = sb[0];
                if (int'(out_idx) != e.idx || out_spike !== e.sp || dut_v() != e.v || int'(out_cnt) != e.c)
                    $display("FAIL %s_beat[%0d]: got i=%0d s=%b v=%0d c=%0d want i=%0d s=%b v=%0d c=%0d",
                             tag, c, out_idx, out_spike, dut_v(), out_cnt, e.idx, e.sp, e.v, e.c);
                else n_pass++;
            end else n_pass++;
            if (out_valid === 1'b1 && out_ready && sb.size() != 0) void'(sb.pop_front());
            if (in_valid && in_ready === 1'b1) begin
                model_step(int'(in_idx), longint'($signed(in_cur)), b);
                sb.push_back(b);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4 && sb.size() != 0; c++) begin
            #1;
            e = sb.pop_front();
            n_total++;
            if (out_valid !== 1'b1 || int'(out_idx) != e.idx || dut_v() != e.v || int'(out_cnt) != e.c)
                $display("FAIL %s_drain: got val=%b i=%0d v=%0d c=%0d want i=%0d v=%0d c=%0d",
                         tag, out_valid, out_idx, dut_v(), out_cnt, e.idx, e.v, e.c);
            else n_pass++;
            @(posedge clk); #1;
        end
        n_total++;
        if (sb.size() != 0 || out_valid !== 1'b0)
            $display("FAIL %s_empty: left=%0d out_valid=%b want 0/0", tag, sb.size(), out_valid);
        else n_pass++;
        sb.delete();
    endtask

    task automatic test_backpressure();
        set_cfg(5000, 3, 1'b0, 1);
        run_stream(30, 6, 1'b0, "backpressure");
    endtask

    task automatic test_random();
        run_stream(400, 0, 1'b1, "random");
    endtask

    task automatic check_all_zero(input string tag);
        beat_t b;
        int bad = 0;
        set_cfg(1000000, 3, 1'b0, 0);
        for (int i = 0; i < N; i++) begin
            send(i, 100, b);
            n_total++;
            if (out_spike !== b.sp || dut_v() != b.v || int'(out_cnt) != b.c || int'(out_idx) != i) begin
                bad++;
                $display("FAIL %s_zero[%0d]: got i=%0d v=%0d c=%0d want v=%0d c=%0d",
                         tag, i, out_idx, dut_v(), out_cnt, b.v, b.c);
            end else n_pass++;
        end
    endtask

    task automatic test_clear();
        beat_t b;
        int n = 0;
        set_cfg(2000, 3, 1'b0, 3);
        for (int i = 0; i < N; i++) send(i, 2500 - 100 * i, b);
        in_valid = 1'b1; in_idx = IW'(7); in_cur = INW'(500); clear_req = 1'b1; out_ready = 1'b1;
        #1;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL clear_prio: in_ready=%b want 0", in_ready);
        else n_pass++;
        @(posedge clk); #1;
        clear_req = 1'b0; in_valid = 1'b0;
        while (busy === 1'b1 && n < 40) begin
            if (n == 5) clear_req = 1'b1;
            @(posedge clk); #1;
            clear_req = 1'b0;
            n++;
        end
        n_total++;
        if (n != N) $display("FAIL clear_busy_len: busy cycles=%0d want %0d", n, N);
        else n_pass++;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL clear_no_beat: out_valid=%b want 0", out_valid);
        else n_pass++;
        model_reset();
        check_all_zero("clear");
    endtask

    task automatic test_reset_mid_clear();
        beat_t b;
        set_cfg(3000, 1, 1'b0, 2);
        send(10, 3500, b);
        send(12, 1000, b);
        send(2, 800, b);
        in_valid = 1'b1; in_idx = IW'(11); in_cur = INW'(900); out_ready = 1'b1;
        @(posedge clk); #1;
        model_step(11, 900, b);
        in_valid = 1'b0; out_ready = 1'b0; clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (busy !== 1'b1 || out_valid !== 1'b1)
            $display("FAIL midclear_pending: busy=%b out_valid=%b want 1/1", busy, out_valid);
        else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        n_total++;
        if (busy !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL midclear_reset: busy=%b out_valid=%b want 0/0", busy, out_valid);
        else n_pass++;
        check_all_zero("midclear");
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_subtract_fire();
        test_zero_refractory();
        test_saturation();
        test_backpressure();
        test_random();
        test_clear();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
